ps2_key_decoder: RTL

// Receives the raw PS/2 keyboard serial line (clock + data, device-driven) and produces the
// 11-bit ps2_key event bus consumed by bally_input: {toggle, pressed, extended, scancode}.

---
 rtl/ps2_key_decoder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises and filters the device-driven clock/data lines, frames
// bytes, and assembles E0/F0/E1 prefixed scancodes into the 11-bit ps2_key event bus.
module ps2_key_decoder #(
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 100000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        frame_err,
  output logic        busy
);

  localparam int FW = $clog2(FILTER) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fe;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] to_cnt;

  logic [7:0]    byte_p1;
  logic          vld_p1;
  logic          bad_p1;

  logic          ext, rel;
  logic [2:0]    skip;

  assign busy = (state != IDLE);

  // Stage p0: synchronisers and clock glitch filter; fe marks an accepted falling edge
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fe       <= 1'b0;
    end else begin
      clk_s1  <= ps2_clk_in;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data_in;
      data_s2 <= data_s1;
      fe      <= 1'b0;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
        fe       <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Stage p1: frame FSM with timeout; checked byte is registered into byte_p1/vld_p1
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      byte_p1   <= '0;
      vld_p1    <= 1'b0;
      bad_p1    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      vld_p1    <= 1'b0;
      bad_p1    <= 1'b0;
      frame_err <= 1'b0;
      if (fe) begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (!data_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            shift   <= {data_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_s2;
            state   <= STOP;
          end
          default: begin
            byte_p1   <= shift;
            vld_p1    <= (^{shift, par_bit}) & data_s2;
            bad_p1    <= ~((^{shift, par_bit}) & data_s2);
            frame_err <= ~((^{shift, par_bit}) & data_s2);
            state     <= IDLE;
          end
        endcase
      end else if (state == IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_MAX) begin
        // abandoned frame: drop back silently, keep any pending prefix flags
        state <= IDLE;
        shift <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // Stage p2: prefix assembler drives the event bus
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ps2_key <= '0;
      ext     <= 1'b0;
      rel     <= 1'b0;
      skip    <= '0;
    end else if (bad_p1) begin
      ext  <= 1'b0;
      rel  <= 1'b0;
      skip <= '0;
    end else if (vld_p1) begin
      if (skip != 3'd0) begin
        skip <= skip - 1'b1;
      end else if (byte_p1 == 8'hE1) begin
        skip <= 3'd7;
        ext  <= 1'b0;
        rel  <= 1'b0;
      end else if (byte_p1 == 8'hE0) begin
        ext <= 1'b1;
      end else if (byte_p1 == 8'hF0) begin
        rel <= 1'b1;
      end else begin
        ps2_key <= {~ps2_key[10], ~rel, ext, byte_p1};
        ext     <= 1'b0;
        rel     <= 1'b0;
      end
    end
  end

endmodule
